// File: rtl/fpu_ss_mem_responder.sv
// fpu_ss cmem responder: one cmem request -> one OBI data access -> one response.
// Optional FPU_SS_MEM_TIMEOUT_EN bounds the REQ/WAIT states with a cycle counter.
package acc_pkg;
  localparam int AddrWidth = 5;
  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } mem_req_type_e;
endpackage

module fpu_ss_mem_responder #(
  parameter int ACC_ADDR_WIDTH = acc_pkg::AddrWidth,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cmem_q_valid_i,
  output logic                      cmem_q_ready_o,
  input  logic [31:0]               cmem_q_laddr_i,
  input  logic [31:0]               cmem_q_wdata_i,
  input  logic [2:0]                cmem_q_width_i,
  input  acc_pkg::mem_req_type_e    cmem_q_req_type_i,
  input  logic                      cmem_q_mode_i,
  input  logic                      cmem_q_spec_i,
  input  logic                      cmem_q_endoftransaction_i,
  input  logic [31:0]               cmem_q_hart_id_i,
  input  logic [ACC_ADDR_WIDTH-1:0] cmem_q_addr_i,
  output logic                      cmem_p_valid_o,
  input  logic                      cmem_p_ready_i,
  output logic [31:0]               cmem_p_rdata_o,
  output logic [4:0]                cmem_p_range_o,
  output logic                      cmem_p_status_o,
  output logic [ACC_ADDR_WIDTH-1:0] cmem_p_addr_o,
  output logic [31:0]               cmem_p_hart_id_o,
  output logic                      data_req_o,
  input  logic                      data_gnt_i,
  output logic [31:0]               data_addr_o,
  output logic                      data_we_o,
  output logic [3:0]                data_be_o,
  output logic [31:0]               data_wdata_o,
  input  logic                      data_rvalid_i,
  input  logic [31:0]               data_rdata_i,
  input  logic                      data_err_i
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_e;

  state_e state_q, state_d;

  logic [31:0]               laddr_q, laddr_d;
  logic [2:0]                width_q, width_d;
  logic                      we_q, we_d;
  logic [31:0]               wdata_q, wdata_d;
  logic [3:0]                be_q, be_d;
  logic [31:0]               hart_q, hart_d;
  logic [ACC_ADDR_WIDTH-1:0] acc_q, acc_d;
  logic                      mode_q, mode_d;
  logic                      eot_q, eot_d;
  logic [31:0]               rdata_q, rdata_d;
  logic [4:0]                range_q, range_d;
  logic                      status_q, status_d;

  logic        is_wr;
  logic        width_ok;
  logic        misaligned;
  logic        dec_err;
  logic [1:0]  off;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [4:0]  req_range;
  logic [31:0] lane;
  logic [31:0] load_data;
  logic        rvalid_ok;

`ifdef FPU_SS_MEM_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            drop_q, drop_d;
  logic            tmo;
  assign tmo       = (cnt_q == CntW'(TIMEOUT_CYCLES));
  assign rvalid_ok = data_rvalid_i && !drop_q;
`else
  assign rvalid_ok = data_rvalid_i;
`endif

  // mode/eot are carried for the interface but never consumed
  logic unused_bits;
  assign unused_bits = ^{mode_q, eot_q, TIMEOUT_CYCLES};

  // Decode the incoming request: legality, lane enables, store replication
  always_comb begin
    is_wr = (cmem_q_req_type_i == acc_pkg::WRITE);
    off   = cmem_q_laddr_i[1:0];
    unique case (cmem_q_width_i)
      3'b000, 3'b001, 3'b010: width_ok = 1'b1;
      3'b100, 3'b101:         width_ok = !is_wr;
      default:                width_ok = 1'b0;
    endcase
    misaligned = ((cmem_q_width_i[1:0] == 2'b01) && off[0])
              || ((cmem_q_width_i[1:0] == 2'b10) && (off != 2'b00));
    dec_err = !width_ok || misaligned || cmem_q_spec_i;
    unique case (cmem_q_width_i[1:0])
      2'b00: begin
        req_be    = 4'b0001 << off;
        req_wdata = {4{cmem_q_wdata_i[7:0]}};
        req_range = 5'd7;
      end
      2'b01: begin
        req_be    = 4'b0011 << off;
        req_wdata = {2{cmem_q_wdata_i[15:0]}};
        req_range = 5'd15;
      end
      default: begin
        req_be    = 4'b1111;
        req_wdata = cmem_q_wdata_i;
        req_range = 5'd31;
      end
    endcase
    if (is_wr) req_range = 5'd31;
  end

  // Pick the addressed lane out of the returned word and extend it
  always_comb begin
    lane = data_rdata_i >> {laddr_q[1:0], 3'b000};
    unique case (width_q)
      3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
      3'b100:  load_data = {24'd0, lane[7:0]};
      3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
      3'b101:  load_data = {16'd0, lane[15:0]};
      default: load_data = lane;
    endcase
  end

  // Transaction FSM: next state, latched fields and handshake outputs
  always_comb begin
    state_d  = state_q;
    laddr_d  = laddr_q;
    width_d  = width_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    hart_d   = hart_q;
    acc_d    = acc_q;
    mode_d   = mode_q;
    eot_d    = eot_q;
    rdata_d  = rdata_q;
    range_d  = range_q;
    status_d = status_q;
    cmem_q_ready_o = 1'b0;
    cmem_p_valid_o = 1'b0;
    data_req_o     = 1'b0;
`ifdef FPU_SS_MEM_TIMEOUT_EN
    cnt_d  = cnt_q;
    drop_d = drop_q;
    if (drop_q && data_rvalid_i) drop_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        cmem_q_ready_o = 1'b1;
        if (cmem_q_valid_i) begin
          laddr_d  = cmem_q_laddr_i;
          width_d  = cmem_q_width_i;
          we_d     = is_wr;
          wdata_d  = req_wdata;
          be_d     = req_be;
          hart_d   = cmem_q_hart_id_i;
          acc_d    = cmem_q_addr_i;
          mode_d   = cmem_q_mode_i;
          eot_d    = cmem_q_endoftransaction_i;
          rdata_d  = '0;
          range_d  = req_range;
          status_d = dec_err;
          state_d  = dec_err ? RESP : REQ;
`ifdef FPU_SS_MEM_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      REQ: begin
`ifdef FPU_SS_MEM_TIMEOUT_EN
        data_req_o = !tmo;
        if (tmo) begin
          status_d = 1'b1;
          rdata_d  = '0;
          state_d  = RESP;
        end else if (data_gnt_i) begin
          cnt_d   = '0;
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
`else
        data_req_o = 1'b1;
        if (data_gnt_i) state_d = WAIT;
`endif
      end
      WAIT: begin
        if (rvalid_ok) begin
          status_d = data_err_i;
          rdata_d  = (we_q || data_err_i) ? '0 : load_data;
          state_d  = RESP;
        end
`ifdef FPU_SS_MEM_TIMEOUT_EN
        else if (tmo) begin
          status_d = 1'b1;
          rdata_d  = '0;
          drop_d   = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
`endif
      end
      RESP: begin
        cmem_p_valid_o = 1'b1;
        if (cmem_p_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and field registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      laddr_q  <= '0;
      width_q  <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      be_q     <= '0;
      hart_q   <= '0;
      acc_q    <= '0;
      mode_q   <= 1'b0;
      eot_q    <= 1'b0;
      rdata_q  <= '0;
      range_q  <= '0;
      status_q <= 1'b0;
`ifdef FPU_SS_MEM_TIMEOUT_EN
      cnt_q  <= '0;
      drop_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      laddr_q  <= laddr_d;
      width_q  <= width_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      hart_q   <= hart_d;
      acc_q    <= acc_d;
      mode_q   <= mode_d;
      eot_q    <= eot_d;
      rdata_q  <= rdata_d;
      range_q  <= range_d;
      status_q <= status_d;
`ifdef FPU_SS_MEM_TIMEOUT_EN
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
`endif
    end
  end

  assign data_addr_o      = {laddr_q[31:2], 2'b00};
  assign data_we_o        = we_q;
  assign data_be_o        = be_q;
  assign data_wdata_o     = wdata_q;
  assign cmem_p_rdata_o   = rdata_q;
  assign cmem_p_range_o   = range_q;
  assign cmem_p_status_o  = status_q;
  assign cmem_p_addr_o    = acc_q;
  assign cmem_p_hart_id_o = hart_q;

endmodule

// File: tb/tb_fpu_ss_mem_responder.sv
// Scoreboard bench for fpu_ss_mem_responder.
// Timeout scenarios run only when FPU_SS_MEM_TIMEOUT_EN is defined.
module tb_fpu_ss_mem_responder;

  localparam int AW  = acc_pkg::AddrWidth;
  localparam int TMO = 8;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic                   cmem_q_valid_i = 1'b0;
  logic                   cmem_q_ready_o;
  logic [31:0]            cmem_q_laddr_i = '0;
  logic [31:0]            cmem_q_wdata_i = '0;
  logic [2:0]             cmem_q_width_i = '0;
  acc_pkg::mem_req_type_e cmem_q_req_type_i = acc_pkg::READ;
  logic                   cmem_q_mode_i = 1'b0;
  logic                   cmem_q_spec_i = 1'b0;
  logic                   cmem_q_eot_i = 1'b0;
  logic [31:0]            cmem_q_hart_id_i = '0;
  logic [AW-1:0]          cmem_q_addr_i = '0;
  logic                   cmem_p_valid_o;
  logic                   cmem_p_ready_i;
  logic [31:0]            cmem_p_rdata_o;
  logic [4:0]             cmem_p_range_o;
  logic                   cmem_p_status_o;
  logic [AW-1:0]          cmem_p_addr_o;
  logic [31:0]            cmem_p_hart_id_o;
  logic                   data_req_o;
  logic                   data_gnt_i;
  logic [31:0]            data_addr_o;
  logic                   data_we_o;
  logic [3:0]             data_be_o;
  logic [31:0]            data_wdata_o;
  logic                   data_rvalid_i;
  logic [31:0]            data_rdata_i;
  logic                   data_err_i;

  fpu_ss_mem_responder #(
    .ACC_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .cmem_q_valid_i(cmem_q_valid_i),
    .cmem_q_ready_o(cmem_q_ready_o),
    .cmem_q_laddr_i(cmem_q_laddr_i),
    .cmem_q_wdata_i(cmem_q_wdata_i),
    .cmem_q_width_i(cmem_q_width_i),
    .cmem_q_req_type_i(cmem_q_req_type_i),
    .cmem_q_mode_i(cmem_q_mode_i),
    .cmem_q_spec_i(cmem_q_spec_i),
    .cmem_q_endoftransaction_i(cmem_q_eot_i),
    .cmem_q_hart_id_i(cmem_q_hart_id_i),
    .cmem_q_addr_i(cmem_q_addr_i),
    .cmem_p_valid_o(cmem_p_valid_o),
    .cmem_p_ready_i(cmem_p_ready_i),
    .cmem_p_rdata_o(cmem_p_rdata_o),
    .cmem_p_range_o(cmem_p_range_o),
    .cmem_p_status_o(cmem_p_status_o),
    .cmem_p_addr_o(cmem_p_addr_o),
    .cmem_p_hart_id_o(cmem_p_hart_id_o),
    .data_req_o(data_req_o),
    .data_gnt_i(data_gnt_i),
    .data_addr_o(data_addr_o),
    .data_we_o(data_we_o),
    .data_be_o(data_be_o),
    .data_wdata_o(data_wdata_o),
    .data_rvalid_i(data_rvalid_i),
    .data_rdata_i(data_rdata_i),
    .data_err_i(data_err_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [31:0]   rdata;
    logic [4:0]    rng;
    logic          ck_rng;
    logic          status;
    logic [31:0]   hart;
    logic [AW-1:0] acc;
    int            lat;
    int            stall;
    int            hs;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mreq_t;

  rsp_t  rsp_q[$];
  mreq_t mreq_q[$];

  int n_chk = 0;
  int n_err = 0;

  int          gnt_dly   = 0;
  int          rv_mode   = 0;
  logic [31:0] mem_rdata = '0;
  logic        mem_err   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic rsp_t mk_rsp(input logic [31:0] rd,
                                  input logic [4:0] rng,
                                  input logic ck, input logic st,
                                  input int lat, input int stl);
    rsp_t r;
    r.rdata = rd; r.rng = rng; r.ck_rng = ck; r.status = st;
    r.hart = '0; r.acc = '0; r.lat = lat; r.stall = stl; r.hs = 0;
    return r;
  endfunction

  function automatic mreq_t mk_m(input logic [31:0] a, input logic we,
                                 input logic [3:0] be,
                                 input logic [31:0] wd);
    mreq_t m;
    m.addr = a; m.we = we; m.be = be; m.wdata = wd;
    return m;
  endfunction

  task automatic wait_idle();
    int t = 0;
    while ((rsp_q.size() != 0 || mreq_q.size() != 0
            || cmem_q_ready_o !== 1'b1) && t < 400) begin
      @(negedge clk_i);
      t++;
    end
    if (t >= 400) chk("idle_timeout", 32'(t), 32'd0);
  endtask

  task automatic issue(input logic [31:0] la, input logic [31:0] wd,
                       input logic [2:0] w, input logic wr,
                       input logic sp, input logic [31:0] rd,
                       input logic er, input int gd, input int rvm,
                       input rsp_t e, input mreq_t m, input logic mem);
    wait_idle();
    gnt_dly   = gd;
    rv_mode   = rvm;
    mem_rdata = rd;
    mem_err   = er;
    e.hart = $urandom;
    e.acc  = AW'($urandom_range(0, (1 << AW) - 1));
    e.hs   = cyc;
    if (mem) mreq_q.push_back(m);
    rsp_q.push_back(e);
    cmem_q_valid_i    = 1'b1;
    cmem_q_laddr_i    = la;
    cmem_q_wdata_i    = wd;
    cmem_q_width_i    = w;
    cmem_q_req_type_i = wr ? acc_pkg::WRITE : acc_pkg::READ;
    cmem_q_spec_i     = sp;
    cmem_q_mode_i     = $urandom_range(0, 1) == 1;
    cmem_q_eot_i      = 1'b1;
    cmem_q_hart_id_i  = e.hart;
    cmem_q_addr_i     = e.acc;
    @(negedge clk_i);
    cmem_q_valid_i = 1'b0;
    cmem_q_laddr_i = $urandom;
    cmem_q_wdata_i = $urandom;
    cmem_q_spec_i  = 1'b0;
  endtask

  // Memory model: checks the OBI request, grants and returns data
  initial begin
    mreq_t m;
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    data_rdata_i  = '0;
    data_err_i    = 1'b0;
    forever begin
      @(negedge clk_i);
      if (data_req_o === 1'b1) begin
        if (mreq_q.size() == 0) begin
          chk("unexpected_req", {31'd0, data_req_o}, 32'd0);
        end else begin
          m = mreq_q.pop_front();
          for (int k = 0; k <= gnt_dly; k++) begin
            chk("req_addr", data_addr_o, m.addr);
            chk("req_we", {31'd0, data_we_o}, {31'd0, m.we});
            chk("req_be", {28'd0, data_be_o}, {28'd0, m.be});
            if (m.we) chk("req_wdata", data_wdata_o, m.wdata);
            chk("req_high", {31'd0, data_req_o}, 32'd1);
            chk("q_ready_req", {31'd0, cmem_q_ready_o}, 32'd0);
            if (k == gnt_dly) data_gnt_i = 1'b1;
            @(negedge clk_i);
          end
          data_gnt_i = 1'b0;
          chk("req_after_gnt", {31'd0, data_req_o}, 32'd0);
          if (rv_mode != 1) begin
            if (rv_mode == 2) begin
              data_rvalid_i = 1'b1;
              data_rdata_i  = 32'hBAD0_BAD0;
              data_err_i    = 1'b0;
              @(negedge clk_i);
            end
            data_rvalid_i = 1'b1;
            data_rdata_i  = mem_rdata;
            data_err_i    = mem_err;
            @(negedge clk_i);
            data_rvalid_i = 1'b0;
            data_err_i    = 1'b0;
            data_rdata_i  = $urandom;
          end
        end
      end
    end
  end

  // Response monitor: pops the scoreboard and checks hold-until-ready
  initial begin
    rsp_t r;
    cmem_p_ready_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (cmem_p_valid_o === 1'b1) begin
        if (rsp_q.size() == 0) begin
          chk("unexpected_rsp", {31'd0, cmem_p_valid_o}, 32'd0);
          cmem_p_ready_i = 1'b1;
          @(negedge clk_i);
          cmem_p_ready_i = 1'b0;
        end else begin
          r = rsp_q[0];
          chk("rsp_latency", 32'(cyc - r.hs), 32'(r.lat));
          for (int k = 0; k <= r.stall; k++) begin
            chk("rsp_valid", {31'd0, cmem_p_valid_o}, 32'd1);
            chk("rsp_rdata", cmem_p_rdata_o, r.rdata);
            chk("rsp_status", {31'd0, cmem_p_status_o},
                {31'd0, r.status});
            if (r.ck_rng)
              chk("rsp_range", {27'd0, cmem_p_range_o}, {27'd0, r.rng});
            chk("rsp_hart", cmem_p_hart_id_o, r.hart);
            chk("rsp_addr", 32'(cmem_p_addr_o), 32'(r.acc));
            chk("q_ready_rsp", {31'd0, cmem_q_ready_o}, 32'd0);
            if (k == r.stall) cmem_p_ready_i = 1'b1;
            @(negedge clk_i);
          end
          cmem_p_ready_i = 1'b0;
          void'(rsp_q.pop_front());
          chk("rsp_released", {31'd0, cmem_p_valid_o}, 32'd0);
          chk("q_ready_back", {31'd0, cmem_q_ready_o}, 32'd1);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk_i);
    chk("rst_q_ready", {31'd0, cmem_q_ready_o}, 32'd1);
    chk("rst_p_valid", {31'd0, cmem_p_valid_o}, 32'd0);
    chk("rst_req", {31'd0, data_req_o}, 32'd0);
    chk("rst_addr", data_addr_o, 32'd0);
    chk("rst_be", {28'd0, data_be_o}, 32'd0);
    chk("rst_rdata", cmem_p_rdata_o, 32'd0);
    chk("rst_hart", cmem_p_hart_id_o, 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // LW aligned, minimum latency
    issue(32'h1000_0004, 0, 3'b010, 0, 0, 32'hDEAD_BEEF, 0, 0, 0,
          mk_rsp(32'hDEAD_BEEF, 31, 1, 0, 3, 0),
          mk_m(32'h1000_0004, 0, 4'b1111, 0), 1);
    // LB / LBU on lane 3
    issue(32'h1000_0003, 0, 3'b000, 0, 0, 32'h80FF_FFFF, 0, 0, 0,
          mk_rsp(32'hFFFF_FF80, 7, 1, 0, 3, 0),
          mk_m(32'h1000_0000, 0, 4'b1000, 0), 1);
    issue(32'h1000_0003, 0, 3'b100, 0, 0, 32'h80FF_FFFF, 0, 0, 0,
          mk_rsp(32'h0000_0080, 7, 1, 0, 3, 0),
          mk_m(32'h1000_0000, 0, 4'b1000, 0), 1);
    // LH / LHU on upper half
    issue(32'h1000_0002, 0, 3'b001, 0, 0, 32'h8001_1234, 0, 0, 0,
          mk_rsp(32'hFFFF_8001, 15, 1, 0, 3, 0),
          mk_m(32'h1000_0000, 0, 4'b1100, 0), 1);
    issue(32'h1000_0002, 0, 3'b101, 0, 0, 32'h8001_1234, 0, 0, 0,
          mk_rsp(32'h0000_8001, 15, 1, 0, 3, 0),
          mk_m(32'h1000_0000, 0, 4'b1100, 0), 1);
    // LBU lane 2
    issue(32'h2000_0002, 0, 3'b100, 0, 0, 32'h00AB_0000, 0, 0, 0,
          mk_rsp(32'h0000_00AB, 7, 1, 0, 3, 0),
          mk_m(32'h2000_0000, 0, 4'b0100, 0), 1);
    // SH / SB with lane replication
    issue(32'h1000_0002, 32'h0000_1234, 3'b001, 1, 0, 0, 0, 0, 0,
          mk_rsp(0, 31, 1, 0, 3, 0),
          mk_m(32'h1000_0000, 1, 4'b1100, 32'h1234_1234), 1);
    issue(32'h1000_0001, 32'h0000_00AB, 3'b000, 1, 0, 0, 0, 0, 0,
          mk_rsp(0, 31, 1, 0, 3, 0),
          mk_m(32'h1000_0000, 1, 4'b0010, 32'hABAB_ABAB), 1);
    // Decode errors: no memory access, quick error response
    issue(32'h1000_0001, 32'h5555_5555, 3'b010, 1, 0, 0, 0, 0, 0,
          mk_rsp(0, 31, 1, 1, 1, 0), mk_m(0, 0, 0, 0), 0);
    issue(32'h1000_0008, 0, 3'b010, 0, 1, 0, 0, 0, 0,
          mk_rsp(0, 31, 1, 1, 1, 0), mk_m(0, 0, 0, 0), 0);
    issue(32'h1000_0008, 0, 3'b011, 0, 0, 0, 0, 0, 0,
          mk_rsp(0, 0, 0, 1, 1, 0), mk_m(0, 0, 0, 0), 0);
    issue(32'h1000_0008, 32'h11, 3'b100, 1, 0, 0, 0, 0, 0,
          mk_rsp(0, 31, 1, 1, 1, 0), mk_m(0, 0, 0, 0), 0);
    issue(32'h1000_0001, 0, 3'b001, 0, 0, 0, 0, 0, 0,
          mk_rsp(0, 0, 0, 1, 1, 1), mk_m(0, 0, 0, 0), 0);
    // Bus error on read
    issue(32'h1000_0008, 0, 3'b010, 0, 0, 32'h5555_5555, 1, 0, 0,
          mk_rsp(0, 31, 1, 1, 3, 0),
          mk_m(32'h1000_0008, 0, 4'b1111, 0), 1);
    // Grant delayed 5 cycles, response held 4 cycles
    issue(32'h2000_0008, 0, 3'b010, 0, 0, 32'h1234_5678, 0, 5, 0,
          mk_rsp(32'h1234_5678, 31, 1, 0, 8, 4),
          mk_m(32'h2000_0008, 0, 4'b1111, 0), 1);
`ifdef FPU_SS_MEM_TIMEOUT_EN
    // rvalid never comes: timeout error, then a stray rvalid is dropped
    issue(32'h3000_0000, 0, 3'b010, 0, 0, 32'h7777_7777, 0, 0, 1,
          mk_rsp(0, 31, 1, 1, 3 + TMO, 0),
          mk_m(32'h3000_0000, 0, 4'b1111, 0), 1);
    issue(32'h3000_0004, 0, 3'b010, 0, 0, 32'hCAFE_F00D, 0, 0, 2,
          mk_rsp(32'hCAFE_F00D, 31, 1, 0, 4, 0),
          mk_m(32'h3000_0004, 0, 4'b1111, 0), 1);
    issue(32'h3000_0008, 0, 3'b010, 0, 0, 32'h0BAD_CAFE, 0, 0, 0,
          mk_rsp(32'h0BAD_CAFE, 31, 1, 0, 3, 0),
          mk_m(32'h3000_0008, 0, 4'b1111, 0), 1);
`endif
    wait_idle();
    repeat (3) @(negedge clk_i);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
